// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side blocks.
//   UART_BYTE_W  width of one transmitted byte
//   UART_SUM_W   width of the running transmit checksum
//   arb_state_t  state of the transmitter arbiter (idle / locked to an owner)
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int UART_SUM_W  = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: finds the first set request bit searching upward from
// ptr and wrapping at N. Purely combinational.
// Parameters:
//   N     number of requesters (2..8)
// Ports:
//   req   in   N     request vector
//   ptr   in   PW    index where the search starts (highest priority)
//   pick  out  PW    index of the chosen request (0 when none)
//   any   out  1     at least one request is set
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] pick,
    output logic          any
);

    // For every search offset, the requester index it lands on after wrapping.
    logic [PW:0]   sum_w [N];
    logic [PW-1:0] idx_w [N];
    logic [N-1:0]  hit_w;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_off
            assign sum_w[gi] = {1'b0, ptr} + (PW+1)'(gi);
            assign idx_w[gi] = (sum_w[gi] >= (PW+1)'(N)) ? PW'(sum_w[gi] - (PW+1)'(N))
                                                          : PW'(sum_w[gi]);
            assign hit_w[gi] = req[idx_w[gi]];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit_w[k]) begin
                pick = idx_w[k];
            end
        end
        any = |hit_w;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters. A
// requester is granted a whole message: it owns the transmitter until its
// byte flagged last is accepted, or until it stalls (req_valid low) for
// IDLE_TIMEOUT cycles, at which point it is evicted. Owners are chosen
// round-robin, one arbitration cycle per grant.
// Optional build macro: UART_ARB_CHECKSUM_EN adds a 32-bit running sum of
// transmitted bytes; without it the checksum port is tied to zero.
// Parameters:
//   N_REQ          number of requesters (2..8)
//   IDLE_TIMEOUT   stall cycles tolerated mid-message before eviction (>=1)
// Ports:
//   clock      in   1         system clock
//   reset_n    in   1         asynchronous active-low reset
//   req_valid  in   N_REQ     requester i presents a byte
//   req_data   in   N_REQ*8   byte of requester i at [8i+7:8i]
//   req_last   in   N_REQ     byte is the last of its message
//   req_ready  out  N_REQ     byte of requester i accepted this cycle
//   tx_valid   out  1         byte presented to the transmitter
//   tx_data    out  8         byte to transmit
//   tx_ready   in   1         transmitter accepts when tx_valid & tx_ready
//   grant      out  N_REQ     one-hot current owner, 0 when unlocked
//   evict      out  1         one-cycle pulse when an owner times out
//   checksum   out  32        running sum of transmitted bytes
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_valid,
    output logic [UART_BYTE_W-1:0]       tx_data,
    input  logic                         tx_ready,
    output logic [N_REQ-1:0]             grant,
    output logic                         evict,
    output logic [UART_SUM_W-1:0]        checksum
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    arb_state_t        state_reg, state_next;
    logic [N_REQ-1:0]  grant_reg, grant_next;
    logic [PTR_W-1:0]  owner_reg, owner_next;
    logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  idle_cnt_reg, idle_cnt_next;
    logic              evict_reg, evict_next;

    logic [UART_BYTE_W-1:0] data_arr [N_REQ];
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   owner_valid;
    logic                   owner_last;
    logic                   release_lock;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
        end
    endgenerate

    uart_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_reg),
        .pick (pick_idx),
        .any  (pick_any)
    );

    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        idle_cnt_next = idle_cnt_reg;
        evict_next    = 1'b0;
        release_lock  = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        req_ready     = '0;

        case (state_reg)
            ARB_IDLE: begin
                // Arbitration cycle: no byte moves while a grant is decided.
                idle_cnt_next = '0;
                if (pick_any) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    owner_next           = pick_idx;
                    state_next           = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                tx_valid             = owner_valid;
                tx_data              = data_arr[owner_reg];
                req_ready[owner_reg] = owner_valid & tx_ready;
                if (owner_valid && tx_ready) begin
                    idle_cnt_next = '0;
                    release_lock  = owner_last;
                end else if (!owner_valid) begin
                    // Only a silent owner counts toward the timeout; a busy
                    // transmitter (valid held, tx_ready low) does not.
                    if (idle_cnt_reg == CNT_LAST) begin
                        evict_next   = 1'b1;
                        release_lock = 1'b1;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
                if (release_lock) begin
                    grant_next    = '0;
                    rr_ptr_next   = (owner_reg == PTR_LAST) ? '0 : owner_reg + 1'b1;
                    idle_cnt_next = '0;
                    state_next    = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ARB_IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            idle_cnt_reg <= '0;
            evict_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            idle_cnt_reg <= idle_cnt_next;
            evict_reg    <= evict_next;
        end
    end

    assign grant = grant_reg;
    assign evict = evict_reg;

`ifdef UART_ARB_CHECKSUM_EN
    logic                  xfer;
    logic [UART_SUM_W-1:0] checksum_reg;

    assign xfer = tx_valid & tx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum_reg <= '0;
        end else if (xfer) begin
            checksum_reg <= checksum_reg + UART_SUM_W'(tx_data);
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, IDLE_TIMEOUT=64).
// Requester byte queues feed the DUT on the falling edge; transfers, grants
// and evictions are logged half a cycle later, one line per event.
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        evict;
    logic [31:0] checksum;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .IDLE_TIMEOUT (64)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .evict     (evict),
        .checksum  (checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester message queues: {last, data} per entry.
    logic [8:0]  mem [4][64];
    int          wr_p [4];
    int          rd_p [4];

    // Event logs written by the driver/monitor process.
    logic [7:0]  tx_log [$];
    int          tx_src [$];
    int          tx_cyc [$];
    int          gnt_log [$];
    int          evict_cyc [$];
    logic [3:0]  evict_gnt [$];
    logic [31:0] sum_model;
    logic [3:0]  prev_grant;
    logic [8:0]  drv_ent;
    int          cyc;
    int          src;

    initial begin
        cyc        = 0;
        sum_model  = 0;
        prev_grant = 0;
        req_valid  = 0;
        req_data   = 0;
        req_last   = 0;
        for (int i = 0; i < 4; i++) begin
            wr_p[i] = 0;
            rd_p[i] = 0;
        end
    end

    always begin
        @(negedge clock);
        cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rd_p[i] < wr_p[i]) begin
                drv_ent            = mem[i][rd_p[i]];
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = drv_ent[7:0];
                req_last[i]        = drv_ent[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #3;
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                src = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) src = i;
                tx_log.push_back(tx_data);
                tx_src.push_back(src);
                tx_cyc.push_back(cyc);
                sum_model = sum_model + {24'h0, tx_data};
                $display("cycle %0d: tx byte 0x%02h from requester %0d", cyc, tx_data, src);
                if (src >= 0) rd_p[src] = rd_p[src] + 1;
            end
            if (evict) begin
                evict_cyc.push_back(cyc);
                evict_gnt.push_back(grant);
                $display("cycle %0d: evict, grant=%b", cyc, grant);
            end
            if (grant != 4'b0 && grant != prev_grant) begin
                src = -1;
                for (int i = 0; i < 4; i++) if (grant[i]) src = i;
                gnt_log.push_back(src);
                $display("cycle %0d: grant to requester %0d", cyc, src);
            end
        end else begin
            sum_model = 0;
        end
        prev_grant = grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wr_p[r]] = {l, d};
        wr_p[r] = wr_p[r] + 1;
    endtask

    function automatic logic drained();
        for (int i = 0; i < 4; i++) if (rd_p[i] != wr_p[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] tx_at(input int idx);
        if (idx < tx_log.size()) return {24'h0, tx_log[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cyc_at(input int idx);
        if (idx < tx_cyc.size()) return tx_cyc[idx];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gnt_at(input int idx);
        if (idx < gnt_log.size()) return gnt_log[idx];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_sum();
`ifdef UART_ARB_CHECKSUM_EN
        return sum_model;
`else
        return 32'h0;
`endif
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (!drained() && k < budget) begin
            nxt();
            k++;
        end
        check(tag, {31'h0, drained()}, 32'h1);
        nxt();
        nxt();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_p[i] = 0;
            rd_p[i] = 0;
        end
        nxt();
        nxt();
        reset_n = 1'b1;
    endtask

    int tb0, gb0, eb0;

    initial begin
        reset_n  = 1'b0;
        tx_ready = 1'b0;
        nxt();
        nxt();
        check("rst_grant", {28'h0, grant}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_req_ready", {28'h0, req_ready}, 32'h0);
        check("rst_evict", {31'h0, evict}, 32'h0);
        check("rst_checksum", checksum, 32'h0);
        reset_n  = 1'b1;
        tx_ready = 1'b1;

        // "Hi" from requester 0.
        nxt();
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b1);
        nxt();
        check("hi_arb_grant", {28'h0, grant}, 32'h0);
        check("hi_arb_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("hi_arb_req_ready", {28'h0, req_ready}, 32'h0);
        nxt();
        check("hi_grant", {28'h0, grant}, 32'h1);
        check("hi_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("hi_tx_data0", {24'h0, tx_data}, 32'h48);
        check("hi_req_ready", {28'h0, req_ready}, 32'h1);
        nxt();
        check("hi_grant_hold", {28'h0, grant}, 32'h1);
        check("hi_tx_data1", {24'h0, tx_data}, 32'h69);
        nxt();
        check("hi_released", {28'h0, grant}, 32'h0);
        check("hi_idle_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("hi_log0", tx_at(0), 32'h48);
        check("hi_log1", tx_at(1), 32'h69);
`ifdef UART_ARB_CHECKSUM_EN
        check("hi_checksum", checksum, 32'h0000_00B1);
`else
        check("hi_checksum", checksum, 32'h0);
`endif

        // Requesters 1 and 2 together from rr_ptr=0: all of 1, then all of 2.
        do_reset();
        tb0 = tx_log.size();
        gb0 = gnt_log.size();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        push(2, 8'h61, 1'b0);
        push(2, 8'h62, 1'b1);
        wait_drain("pair_drain", 40);
        check("pair_b0", tx_at(tb0 + 0), 32'h41);
        check("pair_b1", tx_at(tb0 + 1), 32'h42);
        check("pair_b2", tx_at(tb0 + 2), 32'h43);
        check("pair_b3", tx_at(tb0 + 3), 32'h61);
        check("pair_b4", tx_at(tb0 + 4), 32'h62);
        check("pair_g0", gnt_at(gb0 + 0), 32'd1);
        check("pair_g1", gnt_at(gb0 + 1), 32'd2);
        check("pair_sum", checksum, exp_sum());

        // Fairness: four requesters with back-to-back single-byte messages.
        do_reset();
        tb0 = tx_log.size();
        gb0 = gnt_log.size();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 4; r++)
                push(r, 8'(16 * (r + 1) + k), 1'b1);
        wait_drain("fair_drain", 60);
        for (int j = 0; j < 8; j++)
            check($sformatf("fair_grant%0d", j), gnt_at(gb0 + j), 32'(j % 4));
        for (int j = 1; j < 8; j++)
            check($sformatf("fair_gap%0d", j), cyc_at(tb0 + j) - cyc_at(tb0 + j - 1), 32'd2);
        check("fair_sum", checksum, exp_sum());

        // Eviction: owner 0 stalls after a non-last byte, requester 1 waits.
        do_reset();
        tb0 = tx_log.size();
        gb0 = gnt_log.size();
        eb0 = evict_cyc.size();
        push(0, 8'h55, 1'b0);
        push(1, 8'h77, 1'b1);
        wait_drain("evict_drain", 200);
        check("evict_count", evict_cyc.size() - eb0, 32'd1);
        if (evict_cyc.size() > eb0) begin
            check("evict_delay", evict_cyc[eb0] - cyc_at(tb0), 32'd65);
            check("evict_grant", {28'h0, evict_gnt[eb0]}, 32'h0);
        end
        check("evict_g0", gnt_at(gb0 + 0), 32'd0);
        check("evict_g1", gnt_at(gb0 + 1), 32'd1);
        check("evict_b0", tx_at(tb0 + 0), 32'h55);
        check("evict_b1", tx_at(tb0 + 1), 32'h77);

        // Transmitter busy for 100 cycles while owner 3 holds a byte.
        do_reset();
        tb0 = tx_log.size();
        eb0 = evict_cyc.size();
        tx_ready = 1'b0;
        push(3, 8'hA5, 1'b1);
        nxt();
        nxt();
        check("busy_grant", {28'h0, grant}, 32'h8);
        for (int k = 0; k < 100; k++) begin
            nxt();
            check("busy_evict", {31'h0, evict}, 32'h0);
            check("busy_req_ready", {28'h0, req_ready}, 32'h0);
            check("busy_tx_data", {24'h0, tx_data}, 32'hA5);
        end
        check("busy_no_tx", tx_log.size() - tb0, 32'd0);
        tx_ready = 1'b1;
        nxt();
        nxt();
        check("busy_b0", tx_at(tb0), 32'hA5);
        check("busy_release", {28'h0, grant}, 32'h0);
        check("busy_no_evict", evict_cyc.size() - eb0, 32'd0);

        // Lone requester re-granted, then a reset mid-message.
        do_reset();
        tb0 = tx_log.size();
        push(2, 8'h01, 1'b1);
        push(2, 8'h02, 1'b1);
        wait_drain("lone_drain", 20);
        check("lone_gap", cyc_at(tb0 + 1) - cyc_at(tb0), 32'd2);
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b0);
        push(2, 8'hC4, 1'b1);
        nxt();
        nxt();
        nxt();
        check("mid_tx_data", {24'h0, tx_data}, 32'hC2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", {28'h0, grant}, 32'h0);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_req_ready", {28'h0, req_ready}, 32'h0);
        check("mid_rst_checksum", checksum, 32'h0);
        for (int i = 0; i < 4; i++) rd_p[i] = wr_p[i];
        nxt();
        reset_n = 1'b1;
        tb0 = tx_log.size();
        gb0 = gnt_log.size();
        push(3, 8'h33, 1'b1);
        push(0, 8'h30, 1'b1);
        wait_drain("after_rst_drain", 20);
        check("after_rst_g0", gnt_at(gb0 + 0), 32'd0);
        check("after_rst_g1", gnt_at(gb0 + 1), 32'd3);
        check("after_rst_b0", tx_at(tb0 + 0), 32'h30);
        check("after_rst_b1", tx_at(tb0 + 1), 32'h33);
        check("after_rst_sum", checksum, exp_sum());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
